pack_stream_to_1d_array: RTL and testbench

//   Upstream feeder for the 1D-to-2D column splitter.
//   - Accepts one BIT_WIDTH element per valid/ready handshake.
//   - Packs COLS elements into the flat COLS*BIT_WIDTH bus: first element in column 0 (LSBs), then column 1, and so on.
//   - Presents the full frame on a valid/ready output. The frame is consumed whole by the splitter stage.

---
 rtl/pack_stream_to_1d_array.sv | 202 ++++++++++++++++++++
 tb/tb_pack_stream_to_1d_array.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_stream_to_1d_array.sv
// ---------------------------------------------------------------------------
// pack_stream_to_1d_array
//   Collects COLS elements of BIT_WIDTH bits, one per valid/ready handshake,
//   into a flat COLS*BIT_WIDTH frame. The first element lands in column 0
//   (the LSBs). The complete frame is then offered on a valid/ready output.
//   Fill and drain never overlap: while a frame is presented, no element is
//   accepted.
//
//   Optional feature macro: PACK_FLUSH_EN
//     Defined   : adds in_last (closes a short frame early) and out_cols
//                 (number of valid columns in the presented frame).
//     Undefined : frames are always exactly COLS elements.
// ---------------------------------------------------------------------------
module pack_stream_to_1d_array #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH-1:0]           in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS*BIT_WIDTH-1:0]      out_data
`ifdef PACK_FLUSH_EN
  ,
  input  logic                           in_last,
  output logic [$clog2(COLS+1)-1:0]      out_cols
`endif
);

  localparam int CNT_W  = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int OC_W   = $clog2(COLS + 1);
  localparam int DATA_W = COLS * BIT_WIDTH;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   data_s;

  logic                accept_s;
  logic                consume_s;
  logic                last_col_s;
  logic                frame_end_s;

  // Handshake qualifiers. in_ready depends on state only, so out_ready never
  // reaches in_ready combinationally.
  assign accept_s   = in_valid & in_ready;
  assign consume_s  = out_valid & out_ready;
  assign last_col_s = (cnt_r == CNT_W'(COLS - 1));

`ifdef PACK_FLUSH_EN
  // A frame closes on the last column or early on in_last.
  assign frame_end_s = last_col_s | in_last;
`else
  // A frame closes only on the last column.
  assign frame_end_s = last_col_s;
`endif

  // State register: async reset returns to FILL, dropping out_valid at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: FILL until the frame closes, FULL until consumed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s && frame_end_s) begin
          state_s = ST_FULL;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

  // Output decode: flow-control flags are a pure function of the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_FILL: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Column counter next value: advance on accept, wrap to 0 when a frame closes.
  always_comb begin
    cnt_s = cnt_r;
    if (accept_s) begin
      if (frame_end_s) begin
        cnt_s = {CNT_W{1'b0}};
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Column counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  // Frame register next value: clear on consume, write column cnt on accept.
  // Clearing on consume is what makes unwritten columns of a short frame read 0.
  always_comb begin
    data_s = data_r;
    if (consume_s) begin
      data_s = {DATA_W{1'b0}};
    end else if (accept_s) begin
      for (int i = 0; i < COLS; i++) begin
        if (cnt_r == CNT_W'(i)) begin
          data_s[i*BIT_WIDTH +: BIT_WIDTH] = in_data;
        end else begin
          data_s[i*BIT_WIDTH +: BIT_WIDTH] = data_r[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end else begin
      data_s = data_r;
    end
  end

  // Frame register: drives out_data directly so the frame is stable in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
    end else begin
      data_r <= data_s;
    end
  end

  assign out_data = data_r;

`ifdef PACK_FLUSH_EN
  logic [OC_W-1:0] cols_r;
  logic [OC_W-1:0] cols_s;

  // Column-count next value: captured when a frame closes, zero outside FULL.
  always_comb begin
    cols_s = cols_r;
    if (consume_s) begin
      cols_s = {OC_W{1'b0}};
    end else if (accept_s && frame_end_s) begin
      cols_s = OC_W'(cnt_r) + OC_W'(1);
    end else begin
      cols_s = cols_r;
    end
  end

  // Column-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_r <= {OC_W{1'b0}};
    end else begin
      cols_r <= cols_s;
    end
  end

  assign out_cols = cols_r;
`endif

endmodule

// File: tb/tb_pack_stream_to_1d_array.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for pack_stream_to_1d_array (BIT_WIDTH=4,
// COLS=8). Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_pack_stream_to_1d_array;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PACK_FLUSH_EN
  logic        in_last;
  logic [3:0]  out_cols;
`endif

  int checks;
  int errors;

  pack_stream_to_1d_array #(.BIT_WIDTH(4), .COLS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PACK_FLUSH_EN
    ,
    .in_last   (in_last),
    .out_cols  (out_cols)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
`ifdef PACK_FLUSH_EN
    in_last = 1'b0;
`endif
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL reset_hold out_valid=%b out_data=%h required 0/00000000", out_valid, out_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL reset_release in_ready=%b out_valid=%b out_data=%h required 1/0/00000000", in_ready, out_valid, out_data);
    end
`ifdef PACK_FLUSH_EN
    checks++;
    if (out_cols !== 4'd0) begin
      errors++; $display("FAIL reset_out_cols got %0d required 0", out_cols);
    end
`endif
  endtask

  // 1..8 back to back with out_ready high: one-cycle frame, then refill.
  task automatic test_stream();
    int fill_bad;
    fill_bad = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 4'(k);
      if (in_ready !== 1'b1 || out_valid !== 1'b0) fill_bad++;
      tick();
    end
    checks++;
    if (fill_bad != 0) begin
      errors++; $display("FAIL stream_fill_flags bad_cycles=%0d required 0", fill_bad);
    end
    in_data = 4'h9;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h87654321) begin
      errors++; $display("FAIL stream_frame out_valid=%b in_ready=%b out_data=%h required 1/0/87654321", out_valid, in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      errors++; $display("FAIL stream_after out_valid=%b in_ready=%b out_data=%h required 0/1/00000000", out_valid, in_ready, out_data);
    end
  endtask

  // Backpressure: frame held while in_valid presents F; F becomes next column 0.
  task automatic test_backpressure();
    int hold_bad;
    hold_bad = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 4'(k);
      tick();
    end
    in_data = 4'hF;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h87654321) hold_bad++;
      tick();
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL bp_hold bad_cycles=%0d required 0", hold_bad);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h87654321) begin
      errors++; $display("FAIL bp_after_hold out_valid=%b out_data=%h required 1/87654321", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    tick();
    for (int k = 2; k <= 8; k++) begin
      in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h8765432F) begin
      errors++; $display("FAIL bp_next_frame out_valid=%b out_data=%h required 1/8765432f", out_valid, out_data);
    end
    tick();
  endtask

  // in_valid toggles; gap cycles carry junk data that must not be captured.
  task automatic test_gaps();
    logic [3:0] elems [8];
    int early;
    elems = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h6, 4'h7};
    early = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = elems[i];
      tick();
      if (i < 7 && out_valid !== 1'b0) early++;
      in_valid = 1'b0; in_data = 4'h3;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL gaps_early_valid count=%0d required 0", early);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h76FEDCBA) begin
      errors++; $display("FAIL gaps_frame out_valid=%b out_data=%h required 1/76fedcba", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
  endtask

  // Reset while FULL and mid-frame; new frame must hold only new data.
  task automatic test_mid_reset();
    logic [3:0] fresh [8];
    fresh = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL rst_full_async out_valid=%b out_data=%h required 0/00000000", out_valid, out_data);
    end
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL rst_partial_async out_valid=%b out_data=%h required 0/00000000", out_valid, out_data);
    end
    #2 rst = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = fresh[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1FEDCBA9) begin
      errors++; $display("FAIL rst_new_frame out_valid=%b out_data=%h required 1/1fedcba9", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
  endtask

`ifdef PACK_FLUSH_EN
  // Short frame closed by in_last, then a full frame.
  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 4'(k);
      in_last = (k == 3) ? 1'b1 : 1'b0;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000321 || out_cols !== 4'd3) begin
      errors++; $display("FAIL flush_short out_valid=%b out_data=%h out_cols=%0d required 1/00000321/3", out_valid, out_data, out_cols);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_cols !== 4'd0 || out_data !== 32'h0) begin
      errors++; $display("FAIL flush_consumed out_valid=%b out_cols=%0d out_data=%h required 0/0/00000000", out_valid, out_cols, out_data);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 4'(k);
      in_last = (k == 8) ? 1'b1 : 1'b0;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h87654321 || out_cols !== 4'd8) begin
      errors++; $display("FAIL flush_full out_valid=%b out_data=%h out_cols=%0d required 1/87654321/8", out_valid, out_data, out_cols);
    end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  // Two frames with out_ready and in_valid constant: second fall after 18 cycles.
  task automatic test_back_to_back();
    int  n;
    int  falls;
    int  fall_at;
    logic prev_valid;
    int  bad_data;
    falls = 0; fall_at = -1; bad_data = 0;
    prev_valid = out_valid;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h7;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (out_valid === 1'b1 && out_data !== 32'h77777777) bad_data++;
      if (prev_valid === 1'b1 && out_valid === 1'b0) begin
        falls++;
        if (falls == 2) begin
          fall_at = n;
          break;
        end
      end
      prev_valid = out_valid;
    end
    in_valid = 1'b0;
    checks++;
    if (fall_at != 18) begin
      errors++; $display("FAIL b2b_latency cycles=%0d required 18 (-1 means timeout)", fall_at);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL b2b_data bad_cycles=%0d required 0", bad_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_gaps();
    test_mid_reset();
`ifdef PACK_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
